// File: rtl/hazard_sequencer.sv
// Pipeline hazard / redirect / debug-drain sequencer for the 5-stage MIPS core.
// Latency: enables and flushes are combinational (0 cycles); FSM and counters update on the next edge.
// Backpressure: mem_busy_i freezes the whole pipeline (except when halted); a hazard holds PC and IF/ID.
//
// Ports:
//   clk_i, rst_ni             clock (rising edge), asynchronous active-low reset
//   id_rs_i, id_rt_i          source register fields of the instruction in ID
//   ex_mem_read_i, ex_reg_write_i, ex_dst_i   EX-stage load / write-back info
//   jump_i, bne_i, jr_i       redirects decoded in ID (bne_i means taken)
//   mem_busy_i                data memory not ready
//   halt_req_i                level-sensitive debug stop request
//   cnt_clr_i                 synchronous clear of both counters
//   pc_write_o, ifid_write_o  PC / IF-ID load enables
//   if_flush_o, id_flush_o    discard IF instruction / zero ID control bits
//   pipe_freeze_o             hold every pipeline register
//   halted_o                  pipeline drained and stopped
//   stall_cnt_o, flush_cnt_o  saturating performance counters
module hazard_sequencer #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             ex_mem_read_i,
    input  logic             ex_reg_write_i,
    input  logic [4:0]       ex_dst_i,
    input  logic             jump_i,
    input  logic             bne_i,
    input  logic             jr_i,
    input  logic             mem_busy_i,
    input  logic             halt_req_i,
    input  logic             cnt_clr_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             if_flush_o,
    output logic             id_flush_o,
    output logic             pipe_freeze_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // Drain counter only ever holds DRAIN_CYCLES-1 down to 1.
    localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic haz, redir, frozen;
    logic stall_inc, flush_inc;

    // Branches resolve in ID, so they also depend on an ALU result still in EX;
    // plain jumps have no register source and never trigger this.
    assign haz = (ex_dst_i != 5'd0)
              && ((ex_dst_i == id_rs_i) || (ex_dst_i == id_rt_i))
              && (ex_mem_read_i || (ex_reg_write_i && (bne_i || jr_i)));

    assign redir  = jump_i | bne_i | jr_i;

    // A halted pipeline has nothing in flight, so memory wait is irrelevant there.
    assign frozen = (state_q != HALTED) && mem_busy_i;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        if_flush_o    = 1'b0;
        id_flush_o    = 1'b0;
        pipe_freeze_o = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;

        if (frozen) begin
            pipe_freeze_o = 1'b1;
            stall_inc     = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (haz) begin
                        // Redirect waits: it is re-decoded once the operand is ready.
                        id_flush_o = 1'b1;
                        stall_inc  = 1'b1;
                    end else if (redir) begin
                        pc_write_o   = 1'b1;
                        ifid_write_o = 1'b1;
                        if_flush_o   = 1'b1;
                        // jump has no ID-stage side effects; bne/jr were fetched
                        // as branches so their control bits are zeroed too.
                        id_flush_o   = bne_i | jr_i;
                        flush_inc    = 1'b1;
                    end else if (halt_req_i) begin
                        // PC stays on the discarded IF instruction so resume refetches it.
                        ifid_write_o = 1'b1;
                        if_flush_o   = 1'b1;
                        drain_d      = DRAIN_INIT;
                        state_d      = DRAIN;
                    end else begin
                        pc_write_o   = 1'b1;
                        ifid_write_o = 1'b1;
                    end
                end
                DRAIN: begin
                    ifid_write_o = 1'b1;
                    if_flush_o   = 1'b1;
                    drain_d      = drain_q - DW'(1);
                    if (drain_q == DRAIN_LAST) begin
                        state_d = HALTED;
                    end
                end
                HALTED: begin
                    ifid_write_o = 1'b1;
                    if_flush_o   = 1'b1;
                    if (!halt_req_i) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end

        // Enables must not leak while reset is held.
        if (!rst_ni) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            if_flush_o    = 1'b0;
            id_flush_o    = 1'b0;
            pipe_freeze_o = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Saturating counters; clear wins over increment
    // ------------------------------------------------------------------
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (cnt_clr_i) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (stall_inc && (stall_q != {CNT_W{1'b1}})) begin
                stall_d = stall_q + CNT_W'(1);
            end
            if (flush_inc && (flush_q != {CNT_W{1'b1}})) begin
                flush_d = flush_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            drain_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign halted_o    = (state_q == HALTED);
    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: constant vector table, hand-written
// multi-cycle sequences, and random traffic against a behavioural model.
// A second instance with 2-bit counters exercises saturation.
module tb_hazard_sequencer;

    localparam int DRAIN_CYCLES = 4;
    localparam int BIG_MAX      = 65535;
    localparam int SML_MAX      = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs = '0, rt = '0, dst = '0;
    logic       memrd = 0, regwr = 0, jmp = 0, bne = 0, jr = 0;
    logic       busy = 0, hreq = 0, clr = 0;

    logic        pc_w, ifid_w, if_fl, id_fl, frz, hlt;
    logic [15:0] st16, fl16;
    logic        pc_w2, ifid_w2, if_fl2, id_fl2, frz2, hlt2;
    logic [1:0]  st2, fl2;

    always #5 clk = ~clk;

    hazard_sequencer #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .id_rs_i(rs), .id_rt_i(rt),
        .ex_mem_read_i(memrd), .ex_reg_write_i(regwr), .ex_dst_i(dst),
        .jump_i(jmp), .bne_i(bne), .jr_i(jr), .mem_busy_i(busy),
        .halt_req_i(hreq), .cnt_clr_i(clr),
        .pc_write_o(pc_w), .ifid_write_o(ifid_w), .if_flush_o(if_fl),
        .id_flush_o(id_fl), .pipe_freeze_o(frz), .halted_o(hlt),
        .stall_cnt_o(st16), .flush_cnt_o(fl16));

    hazard_sequencer #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(2)) dut_s (
        .clk_i(clk), .rst_ni(rst_n), .id_rs_i(rs), .id_rt_i(rt),
        .ex_mem_read_i(memrd), .ex_reg_write_i(regwr), .ex_dst_i(dst),
        .jump_i(jmp), .bne_i(bne), .jr_i(jr), .mem_busy_i(busy),
        .halt_req_i(hreq), .cnt_clr_i(clr),
        .pc_write_o(pc_w2), .ifid_write_o(ifid_w2), .if_flush_o(if_fl2),
        .id_flush_o(id_fl2), .pipe_freeze_o(frz2), .halted_o(hlt2),
        .stall_cnt_o(st2), .flush_cnt_o(fl2));

    int n_vec = 0;
    int n_err = 0;

    // ---------------- behavioural model ----------------
    bit m_halted, m_drain;
    int m_left;            // non-frozen drain cycles still to go before halting
    int m_st, m_fl, m_st2, m_fl2;

    function automatic bit f_haz();
        return (dst != 0) && (dst == rs || dst == rt) && (memrd || (regwr && (bne || jr)));
    endfunction

    // {PC_write, IFID_write, IF_flush, ID_flush, pipe_freeze, halted}
    function automatic logic [5:0] model_out();
        if (m_halted)               return 6'b011001;
        if (busy)                   return 6'b000010;
        if (m_drain)                return 6'b011000;
        if (f_haz())                return 6'b000100;
        if (jmp || bne || jr)       return {3'b111, bne | jr, 2'b00};
        if (hreq)                   return 6'b011000;
        return 6'b110000;
    endfunction

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_halted = 0; m_drain = 0; m_left = 0;
        m_st = 0; m_fl = 0; m_st2 = 0; m_fl2 = 0;
    endtask

    task automatic model_step();
        bit h, r, si, fi;
        h  = f_haz();
        r  = jmp || bne || jr;
        si = !m_halted && (busy || (!m_drain && h));
        fi = !m_halted && !busy && !m_drain && !h && r;
        if (clr) begin
            m_st = 0; m_fl = 0; m_st2 = 0; m_fl2 = 0;
        end else begin
            m_st  = sat(m_st + int'(si), BIG_MAX);
            m_fl  = sat(m_fl + int'(fi), BIG_MAX);
            m_st2 = sat(m_st2 + int'(si), SML_MAX);
            m_fl2 = sat(m_fl2 + int'(fi), SML_MAX);
        end
        if (m_halted) begin
            if (!hreq) m_halted = 0;
        end else if (busy) begin
            // pipeline held: nothing moves
        end else if (m_drain) begin
            m_left--;
            if (m_left == 0) begin m_drain = 0; m_halted = 1; end
        end else if (!h && !r && hreq) begin
            m_drain = 1;
            m_left  = DRAIN_CYCLES - 1;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] outs();
        return {pc_w, ifid_w, if_fl, id_fl, frz, hlt};
    endfunction

    function automatic logic [5:0] outs2();
        return {pc_w2, ifid_w2, if_fl2, id_fl2, frz2, hlt2};
    endfunction

    task automatic set_in(input logic [4:0] a_rs, input logic [4:0] a_rt, input logic [4:0] a_dst,
                          input logic a_mr, input logic a_rw, input logic a_j, input logic a_b,
                          input logic a_jr, input logic a_busy, input logic a_h, input logic a_clr);
        rs = a_rs; rt = a_rt; dst = a_dst; memrd = a_mr; regwr = a_rw;
        jmp = a_j; bne = a_b; jr = a_jr; busy = a_busy; hreq = a_h; clr = a_clr;
    endtask

    // One clock cycle: compare at the falling edge, advance the model, return after the rising edge.
    task automatic step(input string nm, input bit use_exp, input logic [5:0] exp);
        @(negedge clk);
        if (use_exp) chk({nm, ".const"}, 32'(outs()), 32'(exp));
        chk({nm, ".outs"},  32'(outs()),  32'(model_out()));
        chk({nm, ".outs2"}, 32'(outs2()), 32'(model_out()));
        model_step();
        @(posedge clk);
        #1;
        chk({nm, ".stall"},  32'(st16), 32'(m_st));
        chk({nm, ".flush"},  32'(fl16), 32'(m_fl));
        chk({nm, ".stall2"}, 32'(st2),  32'(m_st2));
        chk({nm, ".flush2"}, 32'(fl2),  32'(m_fl2));
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);   // jump would enable PC_write if not gated
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("reset.outs", 32'(outs()), 32'd0);
        chk("reset.stall", 32'(st16), 32'd0);
        chk("reset.flush", 32'(fl16), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- constant vector table (all applied in RUN) ----------------
    typedef struct {
        logic [4:0] rs, rt, dst;
        logic       mr, rw, j, b, r, busy, h;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        bit hz;
        tbl[0]  = '{5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000100}; // load-use rs
        tbl[1]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110000}; // $0 never stalls
        tbl[2]  = '{5'd1, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000100}; // load-use rt
        tbl[3]  = '{5'd8, 5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110000}; // ALU dep, no branch
        tbl[4]  = '{5'd8, 5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000100}; // bne on ALU result
        tbl[5]  = '{5'd9, 5'd7, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b111100}; // bne, independent
        tbl[6]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111000}; // jump
        tbl[7]  = '{5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b111100}; // jr
        tbl[8]  = '{5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000100}; // haz beats all
        tbl[9]  = '{5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000010}; // freeze beats haz
        tbl[10] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000010}; // freeze beats halt
        tbl[11] = '{5'd8, 5'd7, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110000}; // no match

        do_reset();
        for (int i = 0; i < 12; i++) begin
            set_in(tbl[i].rs, tbl[i].rt, tbl[i].dst, tbl[i].mr, tbl[i].rw,
                   tbl[i].j, tbl[i].b, tbl[i].r, tbl[i].busy, tbl[i].h, 1'b0);
            step($sformatf("tbl%0d", i), 1'b1, tbl[i].exp);
        end

        // ---- load-use counter 0 -> 1 ----
        do_reset();
        set_in(8, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0);
        step("loaduse", 1'b1, 6'b000100);
        chk("loaduse.cnt", 32'(st16), 32'd1);

        // ---- jr waiting on an ALU result ----
        do_reset();
        set_in(31, 0, 31, 0, 1, 0, 0, 1, 0, 0, 0);
        step("jr.stall", 1'b1, 6'b000100);
        set_in(31, 0, 5, 0, 1, 0, 0, 1, 0, 0, 0);
        step("jr.go", 1'b1, 6'b111100);
        chk("jr.flushcnt", 32'(fl16), 32'd1);

        // ---- redirect beats halt, halt accepted next cycle ----
        do_reset();
        set_in(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        step("redir_halt", 1'b1, 6'b111000);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("halt_acc", 1'b1, 6'b011000);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // drop of halt_req does not abort
        step("drain1", 1'b1, 6'b011000);

        // ---- drain with one frozen cycle: accepted N, halted N+5 ----
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("dr.acc", 1'b1, 6'b011000);            // N
        step("dr.n1", 1'b1, 6'b011000);             // N+1
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step("dr.frz", 1'b1, 6'b000010);            // N+2 frozen
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("dr.n3", 1'b1, 6'b011000);             // N+3
        step("dr.n4", 1'b1, 6'b011000);             // N+4 still not halted
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step("dr.halted", 1'b1, 6'b011001);         // N+5, mem_busy ignored
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("dr.release", 1'b1, 6'b011001);        // N+6
        step("dr.resume", 1'b1, 6'b110000);         // N+7

        // ---- saturation and clear on the 2-bit instance ----
        do_reset();
        set_in(4, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("sat", 1'b1, 6'b000100);
        chk("sat.cnt2", 32'(st2), 32'd3);
        chk("sat.cnt16", 32'(st16), 32'd5);
        set_in(4, 0, 4, 1, 0, 0, 0, 0, 0, 0, 1);
        step("clr", 1'b1, 6'b000100);
        chk("clr.cnt2", 32'(st2), 32'd0);
        chk("clr.cnt16", 32'(st16), 32'd0);

        // ---- asynchronous reset mid-drain ----
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("ar.acc", 1'b1, 6'b011000);
        step("ar.drain", 1'b1, 6'b011000);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("ar.outs", 32'(outs()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        step("ar.run", 1'b1, 6'b110000);

        // ---- random traffic against the model ----
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rs    = 5'($urandom_range(0, 3));
            rt    = 5'($urandom_range(0, 3));
            dst   = 5'($urandom_range(0, 3));
            memrd = ($urandom_range(0, 3) == 0);
            regwr = $urandom_range(0, 1) == 1;
            jmp   = ($urandom_range(0, 7) == 0);
            bne   = ($urandom_range(0, 7) == 0);
            jr    = ($urandom_range(0, 9) == 0);
            busy  = ($urandom_range(0, 7) == 0);
            clr   = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 9) == 0) hreq = ~hreq;
            hz = f_haz();
            step("rand", 1'b0, 6'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
